// File: rtl/cache_pkg.sv
// Shared types for the cache fill controller.
// State encodings and a constant log2 helper for offset widths.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    TAG  = 2'b10
  } fill_state_e;

  // Usable in parameter context; n is a power of two here.
  function automatic int log2i(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Miss, memory and array-write signals of the fill controller.
// master = controller side, slave = tag logic / memory side.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int WOFF_W = 3
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              mem_req_ready;
  logic              memory_data_valid;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [WOFF_W-1:0] data_word_offset;
  logic              write_tag_array;
  logic [ADDR_W-1:0] tag_address;
  logic              fsm_busy;
  logic              fill_err;

  modport master (
    input  miss_detected,
    input  miss_address,
    input  mem_req_ready,
    input  memory_data_valid,
    output mem_rd_en,
    output memory_address,
    output write_data_array,
    output data_word_offset,
    output write_tag_array,
    output tag_address,
    output fsm_busy,
    output fill_err
  );

  modport slave (
    output miss_detected,
    output miss_address,
    output mem_req_ready,
    output memory_data_valid,
    input  mem_rd_en,
    input  memory_address,
    input  write_data_array,
    input  data_word_offset,
    input  write_tag_array,
    input  tag_address,
    input  fsm_busy,
    input  fill_err
  );
endinterface

// File: rtl/dff.sv
// Enabled register with asynchronous active-high reset to zero.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear; clear wins over increment.
module fill_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic             w_en;
  logic [WIDTH-1:0] w_d;

  assign w_en = i_clr | i_inc;
  assign w_d  = i_clr ? '0 : o_cnt + WIDTH'(1);

  dff #(.WIDTH(WIDTH)) u_q (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_en),
    .i_d   (w_d),
    .o_q   (o_cnt)
  );

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache-miss block fill: one read per word, per-word data writes,
// then a single tag write. fsm_busy stalls the pipeline.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int WORD_BYTES  = 2
) (
  input logic               clk,
  input logic               rst,
  cache_fill_ctrl_if.master bus
);

  localparam int WOFF_W = log2i(BLOCK_WORDS);
  localparam int BOFF_W = log2i(BLOCK_WORDS * WORD_BYTES);
  localparam int BYTE_W = log2i(WORD_BYTES);
  localparam int CNT_W  = WOFF_W + 1;

  localparam logic [ADDR_W-1:0] BLK_MASK =
    ~((ADDR_W'(1) << BOFF_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

  logic [1:0]        r_state_q;
  fill_state_e       w_state;
  fill_state_e       w_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_base_d;
  logic [CNT_W-1:0]  r_iss;
  logic [CNT_W-1:0]  r_ret;
  logic              r_err;

  logic w_clr;
  logic w_base_en;
  logic w_iss_inc;
  logic w_ret_inc;
  logic w_err_set;
  logic w_rd_en;
  logic w_wr;
  logic w_tag;
  logic w_fill;

  assign w_state  = fill_state_e'(r_state_q);
  assign w_fill   = (w_state == FILL);
  assign w_base_d = bus.miss_address & BLK_MASK;

  always_comb begin
    w_nxt     = w_state;
    w_clr     = 1'b0;
    w_base_en = 1'b0;
    w_iss_inc = 1'b0;
    w_ret_inc = 1'b0;
    w_err_set = 1'b0;
    w_rd_en   = 1'b0;
    w_wr      = 1'b0;
    w_tag     = 1'b0;
    unique case (1'b1)
      (w_state == IDLE): begin
        if (bus.miss_detected) begin
          w_nxt     = FILL;
          w_clr     = 1'b1;
          w_base_en = 1'b1;
        end
      end
      (w_state == FILL): begin
        w_rd_en   = (r_iss < CNT_FULL);
        w_iss_inc = w_rd_en & bus.mem_req_ready;
        w_wr      = bus.memory_data_valid;
        w_ret_inc = bus.memory_data_valid;
        // A word with no request outstanding is still kept, but flagged.
        w_err_set = bus.memory_data_valid & (r_ret >= r_iss);
        if (bus.memory_data_valid && (r_ret == CNT_LAST)) begin
          w_nxt = TAG;
        end
      end
      (w_state == TAG): begin
        w_tag = 1'b1;
        w_nxt = IDLE;
      end
      default: begin
        w_nxt = IDLE;
      end
    endcase
  end

  dff #(.WIDTH(2)) u_state (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (1'b1),
    .i_d   (w_nxt),
    .o_q   (r_state_q)
  );

  dff #(.WIDTH(ADDR_W)) u_base (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_base_en),
    .i_d   (w_base_d),
    .o_q   (r_base)
  );

  dff #(.WIDTH(1)) u_err (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_err_set),
    .i_d   (1'b1),
    .o_q   (r_err)
  );

  fill_counter #(.WIDTH(CNT_W)) u_iss (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_clr),
    .i_inc (w_iss_inc),
    .o_cnt (r_iss)
  );

  fill_counter #(.WIDTH(CNT_W)) u_ret (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_clr),
    .i_inc (w_ret_inc),
    .o_cnt (r_ret)
  );

  // OR is an add here: base has its low BOFF_W bits clear.
  assign bus.memory_address   = w_fill ?
    (r_base | (ADDR_W'(r_iss) << BYTE_W)) : '0;
  assign bus.mem_rd_en        = w_rd_en;
  assign bus.write_data_array = w_wr;
  assign bus.data_word_offset = w_fill ? r_ret[WOFF_W-1:0] : '0;
  assign bus.write_tag_array  = w_tag;
  assign bus.tag_address      = w_tag ? r_base : '0;
  assign bus.fsm_busy         = (w_state != IDLE);
  assign bus.fill_err         = r_err;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: default 16/8/2 instance
// plus a 32/4/4 instance for the parameter sweep.
module tb_cache_fill_ctrl;

  localparam int AW  = 16;
  localparam int BW  = 8;
  localparam int WB  = 2;
  localparam int WW  = 3;
  localparam int AW2 = 32;
  localparam int BW2 = 4;
  localparam int WB2 = 4;
  localparam int WW2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_W(AW), .WOFF_W(WW)) bus ();
  cache_fill_ctrl_if #(.ADDR_W(AW2), .WOFF_W(WW2)) bus2 ();

  cache_fill_ctrl #(
    .ADDR_W(AW), .BLOCK_WORDS(BW), .WORD_BYTES(WB)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cache_fill_ctrl #(
    .ADDR_W(AW2), .BLOCK_WORDS(BW2), .WORD_BYTES(WB2)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_req = 0;
  int n_wr = 0;
  int n_tag = 0;
  int ready_mode = 0;
  int gap_max = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_off_q[$];
  logic [31:0] exp_tag_q[$];
  int due_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_fill(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'(BW * WB - 1);
    for (int i = 0; i < BW; i++) begin
      exp_addr_q.push_back(b + 32'(i * WB));
      exp_off_q.push_back(32'(i));
    end
    exp_tag_q.push_back(b);
  endtask

  // One cycle of the memory model on the default instance.
  task automatic step();
    logic rdy;
    logic vld;
    logic en;
    logic [31:0] a;
    int d;
    @(negedge clk);
    cyc++;
    en = bus.mem_rd_en;
    a  = 32'(bus.memory_address);
    if (prev_stall) begin
      chk("hold_en", 32'(en), 32'd1);
      chk("hold_addr", a, prev_addr);
    end
    rdy = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    vld = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      vld = 1'b1;
      void'(due_q.pop_front());
    end
    bus.mem_req_ready     = rdy;
    bus.memory_data_valid = vld;
    prev_stall = en & ~rdy;
    prev_addr  = a;
    if (en && rdy) begin
      n_req++;
      if (exp_addr_q.size() == 0) chk("req_extra", 32'd1, 32'd0);
      else chk("req_addr", a, exp_addr_q.pop_front());
      d = cyc + 1;
      if (gap_max > 0) d += int'($urandom_range(gap_max, 0));
      if (due_q.size() > 0 && d < due_q[$]) d = due_q[$];
      due_q.push_back(d);
    end
    #1;
    if (bus.write_data_array) begin
      n_wr++;
      if (exp_off_q.size() == 0) chk("wr_extra", 32'd1, 32'd0);
      else chk("wr_off", 32'(bus.data_word_offset), exp_off_q.pop_front());
    end
    if (bus.write_tag_array) begin
      n_tag++;
      if (exp_tag_q.size() == 0) chk("tag_extra", 32'd1, 32'd0);
      else chk("tag_addr", 32'(bus.tag_address), exp_tag_q.pop_front());
    end
  endtask

  task automatic wait_tag(output int steps);
    int t0;
    t0 = n_tag;
    steps = 0;
    while (n_tag == t0 && steps < 300) begin
      step();
      steps++;
    end
    if (n_tag == t0) chk("tag_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s;
    int r0;
    int w0;
    int t0;
    int g;
    int tags2;
    logic en;
    logic rdy;
    logic vld;
    logic [31:0] a;
    logic [31:0] exp2_addr[$];
    logic [31:0] exp2_off[$];
    int due2[$];

    bus.miss_detected      = 1'b0;
    bus.miss_address       = '0;
    bus.mem_req_ready      = 1'b0;
    bus.memory_data_valid  = 1'b0;
    bus2.miss_detected     = 1'b0;
    bus2.miss_address      = '0;
    bus2.mem_req_ready     = 1'b0;
    bus2.memory_data_valid = 1'b0;

    // reset state
    #12;
    chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst_addr", 32'(bus.memory_address), 32'd0);
    chk("rst_wr", 32'(bus.write_data_array), 32'd0);
    chk("rst_tag", 32'(bus.write_tag_array), 32'd0);
    chk("rst_busy", 32'(bus.fsm_busy), 32'd0);
    chk("rst_err", 32'(bus.fill_err), 32'd0);
    chk("rst2_busy", 32'(bus2.fsm_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: plain fill, latency and busy fall
    ready_mode = 0;
    gap_max = 0;
    w0 = n_wr;
    expect_fill(32'h1233);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1233;
    step();
    bus.miss_detected = 1'b0;
    chk("t1_busy", 32'(bus.fsm_busy), 32'd1);
    wait_tag(s);
    chk("t1_latency", 32'(s + 1), 32'(BW + 2));
    step();
    chk("t1_busy_fall", 32'(bus.fsm_busy), 32'd0);
    chk("t1_writes", 32'(n_wr - w0), 32'(BW));

    // 2: ready toggling 1,0,0
    ready_mode = 1;
    r0 = n_req;
    expect_fill(32'h4567);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h4567;
    step();
    bus.miss_detected = 1'b0;
    wait_tag(s);
    step();
    chk("t2_req_count", 32'(n_req - r0), 32'(BW));
    chk("t2_addr_left", 32'(exp_addr_q.size()), 32'd0);

    // 3: random return gaps
    ready_mode = 0;
    gap_max = 10;
    w0 = n_wr;
    t0 = n_tag;
    expect_fill(32'hA5B7);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'hA5B7;
    step();
    bus.miss_detected = 1'b0;
    wait_tag(s);
    step();
    chk("t3_writes", 32'(n_wr - w0), 32'(BW));
    chk("t3_tags", 32'(n_tag - t0), 32'd1);
    chk("t3_fill_err", 32'(bus.fill_err), 32'd0);
    chk("t3_due_left", 32'(due_q.size()), 32'd0);
    gap_max = 0;

    // 4: miss held high with another address during the fill
    expect_fill(32'h1233);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1233;
    step();
    bus.miss_address  = 16'hFFFF;
    wait_tag(s);
    step();
    chk("t4_idle_gap", 32'(bus.fsm_busy), 32'd0);
    expect_fill(32'hFFFF);
    step();
    chk("t4_refill_busy", 32'(bus.fsm_busy), 32'd1);
    bus.miss_detected = 1'b0;
    wait_tag(s);
    step();
    chk("t4_busy_fall", 32'(bus.fsm_busy), 32'd0);
    chk("t4_off_left", 32'(exp_off_q.size()), 32'd0);

    // 5: reset after the third returned word
    w0 = n_wr;
    expect_fill(32'h2222);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h2222;
    step();
    bus.miss_detected = 1'b0;
    g = 0;
    while (n_wr - w0 < 3 && g < 50) begin
      step();
      g++;
    end
    chk("t5_three_words", 32'(n_wr - w0), 32'd3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("t5_addr", 32'(bus.memory_address), 32'd0);
    chk("t5_wr", 32'(bus.write_data_array), 32'd0);
    chk("t5_tag", 32'(bus.write_tag_array), 32'd0);
    chk("t5_busy", 32'(bus.fsm_busy), 32'd0);
    exp_addr_q.delete();
    exp_off_q.delete();
    exp_tag_q.delete();
    due_q.delete();
    prev_stall = 1'b0;
    bus.memory_data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.memory_data_valid = 1'b1;
    #1;
    chk("t5_idle_wr", 32'(bus.write_data_array), 32'd0);
    @(negedge clk);
    bus.memory_data_valid = 1'b0;
    chk("t5_idle_tag", 32'(bus.write_tag_array), 32'd0);
    chk("t5_idle_busy", 32'(bus.fsm_busy), 32'd0);

    // 6: 32-bit, 4 words of 4 bytes; early valid flags an error
    for (int i = 0; i < BW2; i++) begin
      exp2_addr.push_back(32'h0000_1230 + 32'(i * WB2));
      exp2_off.push_back(32'(i));
    end
    tags2 = 0;
    bus2.miss_detected = 1'b1;
    bus2.miss_address  = 32'h0000_1234;
    @(negedge clk);
    bus2.miss_detected = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      en  = bus2.mem_rd_en;
      a   = bus2.memory_address;
      rdy = (k > 0);
      vld = (k == 0);
      if (due2.size() > 0 && due2[0] <= k) begin
        vld = 1'b1;
        void'(due2.pop_front());
      end
      bus2.mem_req_ready     = rdy;
      bus2.memory_data_valid = vld;
      if (en && rdy) begin
        if (exp2_addr.size() == 0) chk("t6_req_extra", 32'd1, 32'd0);
        else chk("t6_req_addr", a, exp2_addr.pop_front());
        due2.push_back(k + 1);
      end
      #1;
      if (bus2.write_data_array) begin
        if (exp2_off.size() == 0) chk("t6_wr_extra", 32'd1, 32'd0);
        else chk("t6_wr_off", 32'(bus2.data_word_offset), exp2_off.pop_front());
      end
      if (bus2.write_tag_array) begin
        tags2++;
        chk("t6_tag_addr", bus2.tag_address, 32'h0000_1230);
      end
      if (k == 1) chk("t6_fill_err", 32'(bus2.fill_err), 32'd1);
    end
    bus2.mem_req_ready     = 1'b0;
    bus2.memory_data_valid = 1'b0;
    chk("t6_tags", 32'(tags2), 32'd1);
    chk("t6_req_left", 32'(exp2_addr.size()), 32'd0);
    chk("t6_off_left", 32'(exp2_off.size()), 32'd0);
    chk("t6_err_sticky", 32'(bus2.fill_err), 32'd1);
    chk("t6_busy", 32'(bus2.fsm_busy), 32'd0);
    chk("t6_dut1_err", 32'(bus.fill_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
